// File: rtl/apb_csr_pkg.sv
// ---------------------------------------------------------------------------
// apb_csr_pkg
// Shared types and constants for the APB CSR register file.
//   apb_state_e : bus-side FSM states (IDLE, WAIT, ACCESS)
//   access_e    : per-register access type (RW, RO, W1C)
//   ADDR_LSB    : number of byte-offset bits below the word index in PADDR
//   access_of() : resolves the RW/W1C mask bits of one register to access_e
//   strb_mask() : expands a 4-bit byte strobe to a 32-bit bit mask
// ---------------------------------------------------------------------------
package apb_csr_pkg;

  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } apb_state_e;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } access_e;

  // RW takes priority when a register is marked both RW and W1C.
  function automatic access_e access_of(input logic rw, input logic w1c);
    if (rw) begin
      return ACC_RW;
    end
    if (w1c) begin
      return ACC_W1C;
    end
    return ACC_RO;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m[k*8 +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_reg_cell.sv
// ---------------------------------------------------------------------------
// csr_reg_cell
// One 32-bit CSR with a fixed access type.
//   clk, rst : clock, synchronous active-high reset
//   we       : commit strobe for a bus write to this register
//   wdata    : write data, wstrb : byte-lane strobes
//   hw_set   : hardware set pulses (only meaningful for W1C)
//   hw_ro    : hardware value returned on reads (only meaningful for RO)
//   q        : stored contents (always 0 for RO)
//   rdata    : value presented to the bus read mux
// ---------------------------------------------------------------------------
module csr_reg_cell
  import apb_csr_pkg::*;
#(
  parameter access_e ACC = ACC_RW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [31:0] hw_set,
  input  logic [31:0] hw_ro,
  output logic [31:0] q,
  output logic [31:0] rdata
);

  logic [31:0] data_q;
  logic [31:0] data_d;
  logic [31:0] lane_mask;

  // Some inputs are irrelevant for a given access type.
  logic unused_inputs;
  assign unused_inputs = ^{we, wdata, wstrb, hw_set, hw_ro};

  always_comb begin
    lane_mask = strb_mask(wstrb);
    data_d    = data_q;
    case (ACC)
      ACC_RW: begin
        if (we) begin
          data_d = (data_q & ~lane_mask) | (wdata & lane_mask);
        end
      end
      ACC_W1C: begin
        // hw_set is OR-ed in after the clear so a same-cycle set survives.
        if (we) begin
          data_d = (data_q & ~(wdata & lane_mask)) | hw_set;
        end else begin
          data_d = data_q | hw_set;
        end
      end
      default: begin
        data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q     = data_q;
  assign rdata = (ACC == ACC_RO) ? hw_ro : data_q;

endmodule

// File: rtl/apb_csr_regfile.sv
// ---------------------------------------------------------------------------
// apb_csr_regfile
// APB slave exposing NREG 32-bit CSRs with programmable wait states.
//   clk, rst      : clock, synchronous active-high reset
//   paddr..pprot  : APB request (pprot is ignored)
//   pready/prdata/pslverr : registered APB response, valid in the ACCESS cycle
//   csr_q         : flattened RW/W1C register contents (RO slots read 0)
//   hw_ro         : flattened hardware values for RO registers
//   hw_set        : flattened set pulses for W1C registers
//   csr_wr_pulse  : one-cycle strobe per register after a committed write
// ---------------------------------------------------------------------------
module apb_csr_regfile
  import apb_csr_pkg::*;
#(
  parameter int              NREG     = 8,
  parameter int              AW       = 12,
  parameter int              WAIT_CYC = 0,
  parameter logic [NREG-1:0] RW_MASK  = '1,
  parameter logic [NREG-1:0] W1C_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  input  logic [2:0]        pprot,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic [NREG*32-1:0] csr_q,
  input  logic [NREG*32-1:0] hw_ro,
  input  logic [NREG*32-1:0] hw_set,
  output logic [NREG-1:0]   csr_wr_pulse
);

  localparam int              IW        = AW - ADDR_LSB;
  localparam logic [NREG-1:0] RO_MASK   = ~(RW_MASK | W1C_MASK);
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYC);

  apb_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pready_q, pready_d;
  logic [31:0]     prdata_q, prdata_d;
  logic            pslverr_q, pslverr_d;
  // Request captured on entry to ACCESS so the commit does not depend on
  // the master holding the bus stable (or psel high) during ACCESS.
  logic [IW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      strb_q, strb_d;
  logic [NREG-1:0] wr_pulse_q, wr_pulse_d;

  logic [31:0]     rd_word [NREG];
  logic [IW:0]     idx_ext;
  logic            hit;
  logic            ro_hit;
  logic            dec_err;
  logic [31:0]     rd_mux;
  logic            enter_access;

  logic unused_pprot;
  assign unused_pprot = ^pprot;

  // Address decode of the live request.
  always_comb begin
    idx_ext = {1'b0, paddr[AW-1:ADDR_LSB]};
    hit     = 1'b0;
    ro_hit  = 1'b0;
    rd_mux  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_ext == (IW+1)'(i)) begin
        hit    = 1'b1;
        ro_hit = RO_MASK[i];
        rd_mux = rd_word[i];
      end
    end
    dec_err = !hit || (paddr[ADDR_LSB-1:0] != '0) || (pwrite && ro_hit);
  end

  // Bus FSM and registered response.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pready_d     = 1'b0;
    prdata_d     = '0;
    pslverr_d    = 1'b0;
    idx_d        = idx_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    enter_access = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          cnt_d = WAIT_INIT;
          if (WAIT_CYC == 0) begin
            enter_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          // Master abandoned the transfer: nothing is committed.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          enter_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_access) begin
      state_d   = ST_ACCESS;
      cnt_d     = '0;
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      prdata_d  = (pwrite || dec_err) ? 32'h0 : rd_mux;
      idx_d     = paddr[AW-1:ADDR_LSB];
      wr_d      = pwrite;
      wdata_d   = pwdata;
      strb_d    = pstrb;
    end
  end

  // The write lands on the clock edge that ends the ACCESS cycle.
  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if ((state_q == ST_ACCESS) && wr_q && !pslverr_q &&
          ({1'b0, idx_q} == (IW+1)'(i))) begin
        wr_pulse_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      localparam access_e ACC = access_of(RW_MASK[gi], W1C_MASK[gi]);
      csr_reg_cell #(
        .ACC(ACC)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_pulse_d[gi]),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .hw_set(hw_set[gi*32 +: 32]),
        .hw_ro (hw_ro[gi*32 +: 32]),
        .q     (csr_q[gi*32 +: 32]),
        .rdata (rd_word[gi])
      );
    end
  endgenerate

  assign pready       = pready_q;
  assign prdata       = prdata_q;
  assign pslverr      = pslverr_q;
  assign csr_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_csr_regfile.sv
// ---------------------------------------------------------------------------
// tb_apb_csr_regfile
// Three register-file instances sharing one APB bus (separate psel each):
// dut 0 with WAIT_CYC=0, dut 1 with WAIT_CYC=3, dut 2 with WAIT_CYC=5.
// Register map: 0,1,4..7 RW; 2 W1C; 3 RO (hw_ro = 0xDEADBEEF).
// ---------------------------------------------------------------------------
module tb_apb_csr_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  paddr;
  logic         psel [3];
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [255:0] hw_ro;
  logic [255:0] hw_set;

  logic         pready_w  [3];
  logic [31:0]  prdata_w  [3];
  logic         pslverr_w [3];
  logic [255:0] csr_q_w   [3];
  logic [7:0]   pulse_w   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_csr_regfile #(.NREG(8), .AW(12), .WAIT_CYC(0),
                    .RW_MASK(8'b1111_0011), .W1C_MASK(8'b0000_0100)) u_dut0 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]),
    .csr_q(csr_q_w[0]), .hw_ro(hw_ro), .hw_set(hw_set), .csr_wr_pulse(pulse_w[0]));

  apb_csr_regfile #(.NREG(8), .AW(12), .WAIT_CYC(3),
                    .RW_MASK(8'b1111_0011), .W1C_MASK(8'b0000_0100)) u_dut1 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]),
    .csr_q(csr_q_w[1]), .hw_ro(hw_ro), .hw_set(hw_set), .csr_wr_pulse(pulse_w[1]));

  apb_csr_regfile #(.NREG(8), .AW(12), .WAIT_CYC(5),
                    .RW_MASK(8'b1111_0011), .W1C_MASK(8'b0000_0100)) u_dut2 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_w[2]), .prdata(prdata_w[2]), .pslverr(pslverr_w[2]),
    .csr_q(csr_q_w[2]), .hw_ro(hw_ro), .hw_set(hw_set), .csr_wr_pulse(pulse_w[2]));

  typedef struct {
    int          dut;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [7:0]  exp_pulse;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One APB transfer on dut d. hs_acc is applied to the W1C register's
  // hw_set slot only during the ACCESS cycle. lat counts cycles from the
  // setup cycle to the cycle in which pready is seen.
  task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [31:0] hs_acc,
                      output logic [31:0] rd, output logic err, output int lat);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    lat = 0;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (!pready_w[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = prdata_w[d];
    err = pslverr_w[d];
    hw_set[95:64] = hs_acc;
    @(posedge clk); #1;
    hw_set[95:64] = '0;
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          seen;

    rst = 1'b1; paddr = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    pstrb = '0; pprot = '0; hw_set = '0; hw_ro = '0;
    hw_ro[127:96] = 32'hDEAD_BEEF;
    for (int d = 0; d < 3; d++) psel[d] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_pready_%0d", d), {31'b0, pready_w[d]}, 32'h0);
      check($sformatf("reset_prdata_%0d", d), prdata_w[d], 32'h0);
      check($sformatf("reset_pslverr_%0d", d), {31'b0, pslverr_w[d]}, 32'h0);
      check($sformatf("reset_pulse_%0d", d), {24'b0, pulse_w[d]}, 32'h0);
      check($sformatf("reset_csr_q_%0d", d), {31'b0, |csr_q_w[d]}, 32'h0);
    end
    rst = 1'b0;

    //         dut wr  addr     wdata          strb  exp_rd         err lat pulse
    vecs[0]  = '{0, 1'b1, 12'h004, 32'hA5A5_1234, 4'hF, 32'h0000_0000, 1'b0, 1, 8'h02};
    vecs[1]  = '{0, 1'b0, 12'h004, 32'h0,         4'h0, 32'hA5A5_1234, 1'b0, 1, 8'h00};
    vecs[2]  = '{0, 1'b0, 12'h00C, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1, 8'h00};
    vecs[3]  = '{0, 1'b1, 12'h00C, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1, 1, 8'h00};
    vecs[4]  = '{0, 1'b0, 12'h00C, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1, 8'h00};
    vecs[5]  = '{0, 1'b1, 12'h020, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 1, 8'h00};
    vecs[6]  = '{0, 1'b1, 12'h006, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 1, 8'h00};
    vecs[7]  = '{0, 1'b0, 12'h004, 32'h0,         4'h0, 32'hA5A5_1234, 1'b0, 1, 8'h00};
    vecs[8]  = '{0, 1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 1, 8'h00};
    vecs[9]  = '{1, 1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 4, 8'h00};
    vecs[10] = '{1, 1'b1, 12'h000, 32'hFFFF_FFFF, 4'h2, 32'h0000_0000, 1'b0, 4, 8'h01};
    vecs[11] = '{1, 1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_FF00, 1'b0, 4, 8'h00};
    vecs[12] = '{1, 1'b1, 12'h004, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0, 4, 8'h02};
    vecs[13] = '{1, 1'b0, 12'h004, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 4, 8'h00};

    for (int v = 0; v < 14; v++) begin
      xfer(vecs[v].dut, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb,
           32'h0, rd, err, lat);
      $display("vec %0d dut %0d %s addr %h wdata %h strb %h -> rd %h err %0d lat %0d pulse %h",
               v, vecs[v].dut, vecs[v].wr ? "WR" : "RD", vecs[v].addr, vecs[v].wdata,
               vecs[v].strb, rd, err, lat, pulse_w[vecs[v].dut]);
      check($sformatf("vec%0d_prdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_pslverr", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_pulse", v), {24'b0, pulse_w[vecs[v].dut]},
            {24'b0, vecs[v].exp_pulse});
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse_drop", v), {24'b0, pulse_w[vecs[v].dut]}, 32'h0);
    end

    check("dut0_csr_q_reg1", csr_q_w[0][63:32], 32'hA5A5_1234);
    check("dut0_csr_q_reg0", csr_q_w[0][31:0], 32'h0);
    check("dut1_csr_q_reg0", csr_q_w[1][31:0], 32'h0000_FF00);

    // W1C register 2 on dut 0.
    @(posedge clk); #1;
    hw_set[95:64] = 32'h11;
    @(posedge clk); #1;
    hw_set[95:64] = 32'h0;
    check("w1c_set_csr_q", csr_q_w[0][95:64], 32'h11);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'hF, 32'h0, rd, err, lat);
    $display("w1c read after hw_set: rd %h", rd);
    check("w1c_rd_set", rd, 32'h11);
    xfer(0, 1'b1, 12'h008, 32'h01, 4'hF, 32'h01, rd, err, lat);
    $display("w1c write 0x01 with same-cycle hw_set bit0: err %0d pulse %h", err, pulse_w[0]);
    check("w1c_collide_pulse", {24'b0, pulse_w[0]}, 32'h04);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'hF, 32'h0, rd, err, lat);
    $display("w1c read after collision: rd %h", rd);
    check("w1c_rd_collide", rd, 32'h11);
    xfer(0, 1'b1, 12'h008, 32'h10, 4'hF, 32'h0, rd, err, lat);
    $display("w1c write 0x10: err %0d", err);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'hF, 32'h0, rd, err, lat);
    $display("w1c read after clear: rd %h", rd);
    check("w1c_rd_clear", rd, 32'h01);
    xfer(0, 1'b1, 12'h008, 32'h01, 4'h2, 32'h0, rd, err, lat);
    $display("w1c write 0x01 lane0 not strobed: err %0d", err);
    check("w1c_unstrobed_keep", csr_q_w[0][95:64], 32'h01);

    // dut 2: reset during the second wait cycle of a write.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel[2] = 1'b0; penable = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (pready_w[2]) seen++;
      @(posedge clk); #1;
    end
    $display("reset mid-transfer: pready cycles %0d reg0 %h", seen, csr_q_w[2][31:0]);
    check("rst_mid_no_pready", seen, 0);
    check("rst_mid_no_write", csr_q_w[2][31:0], 32'h0);
    check("rst_clears_dut0_reg1", csr_q_w[0][63:32], 32'h0);

    // dut 2: psel dropped during WAIT abandons the write.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0; penable = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (pready_w[2] || (pulse_w[2] != 8'h0)) seen++;
      @(posedge clk); #1;
    end
    $display("psel drop in WAIT: response cycles %0d", seen);
    check("psel_drop_no_response", seen, 0);
    xfer(2, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0, rd, err, lat);
    $display("dut2 read reg1: rd %h lat %0d", rd, lat);
    check("psel_drop_no_write", rd, 32'h0);
    check("dut2_latency", lat, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
